// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the WB stage (priority)
// and the MDU (valid/ready), with a bounded-wait stall and an MDU pending-write scoreboard.
module regfile_wb_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wb_valid,
   input  logic [ADDR_W-1:0]    wb_addr,
   input  logic [DATA_W-1:0]    wb_data,
   input  logic                 mdu_valid,
   input  logic [ADDR_W-1:0]    mdu_addr,
   input  logic [DATA_W-1:0]    mdu_data,
   output logic                 mdu_ready,
   input  logic                 issue_valid,
   input  logic [ADDR_W-1:0]    issue_addr,
   input  logic [ADDR_W-1:0]    rs1_addr,
   input  logic [ADDR_W-1:0]    rs2_addr,
   output logic                 hazard1,
   output logic                 hazard2,
   output logic                 stall_wb,
   output logic                 rf_we,
   output logic [ADDR_W-1:0]    rf_waddr,
   output logic [DATA_W-1:0]    rf_wdata,
   output logic [2**ADDR_W-1:0] busy_mask,
   output logic                 protocol_err
);
   localparam int NREG = 2 ** ADDR_W;
   localparam int CW   = $clog2(MAX_WAIT + 1);
   typedef enum logic [1:0] {IDLE, WAIT, STALL} state_t;
   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            stall_q, pend_q, err_q, err_d;
   logic [NREG-1:0] busy_q, busy_d;
   logic            mdu_fire, blocked;
   logic [ADDR_W-1:0] g_addr;
   assign mdu_ready    = ~reset & (stall_q | ~wb_valid);
   assign mdu_fire     = mdu_valid & mdu_ready;
   assign blocked      = mdu_valid & ~mdu_ready;
   assign g_addr       = mdu_fire ? mdu_addr : wb_addr;
   assign rf_we        = ~reset & (mdu_fire | wb_valid) & (g_addr != '0);
   assign rf_waddr     = g_addr;
   assign rf_wdata     = mdu_fire ? mdu_data : wb_data;
   assign stall_wb     = stall_q;
   assign busy_mask    = busy_q;
   assign protocol_err = err_q;
   // A register being written by the MDU this cycle is forwarded, so it is not a hazard
   assign hazard1 = busy_q[rs1_addr] & ~(mdu_fire & (mdu_addr == rs1_addr));
   assign hazard2 = busy_q[rs2_addr] & ~(mdu_fire & (mdu_addr == rs2_addr));
   always_comb begin
      busy_d = busy_q;
      if (mdu_fire) busy_d[mdu_addr] = 1'b0;
      if (issue_valid && issue_addr != '0) busy_d[issue_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end
   assign err_d = err_q | (wb_valid & stall_q) | (pend_q & ~mdu_valid)
                | (issue_valid & (issue_addr != '0) & busy_q[issue_addr]
                   & ~(mdu_fire & (mdu_addr == issue_addr)));
   // cnt_q is 0 in IDLE, so IDLE and WAIT share the blocked-cycle rule
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         stall_q <= 1'b0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= '0;
      end else begin
         busy_q  <= busy_d;
         err_q   <= err_d;
         pend_q  <= mdu_valid & ~mdu_fire;
         state_q <= IDLE;
         cnt_q   <= '0;
         stall_q <= 1'b0;
         if (blocked && state_q != STALL) begin
            if (cnt_q == CW'(MAX_WAIT - 1)) begin
               state_q <= STALL;
               stall_q <= 1'b1;
            end else begin
               state_q <= WAIT;
               cnt_q   <= cnt_q + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random stimulus checked against a behavioural model
// of the write-port arbiter (consecutive-blocked-cycle count, scoreboard bit array).
module tb_regfile_wb_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int MW = 4;
   localparam int NR = 2 ** AW;
   logic clk = 1'b0, reset = 1'b1;
   logic wb_valid = 0, mdu_valid = 0, issue_valid = 0;
   logic [AW-1:0] wb_addr = '0, mdu_addr = '0, issue_addr = '0, rs1_addr = '0, rs2_addr = '0;
   logic [DW-1:0] wb_data = '0, mdu_data = '0;
   logic mdu_ready, hazard1, hazard2, stall_wb, rf_we, protocol_err;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [NR-1:0] busy_mask;
   int checks = 0, errors = 0;
   bit m_stall, m_err, m_pend;
   int m_wait;
   logic [NR-1:0] m_busy;

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
      .clk(clk), .reset(reset),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard1(hazard1), .hazard2(hazard2),
      .stall_wb(stall_wb), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy_mask(busy_mask), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_stall = 0; m_err = 0; m_pend = 0; m_wait = 0; m_busy = '0;
   endtask

   // one clock cycle: check combinational and registered outputs, then advance the model
   task automatic step(input string tag);
      bit rdy, fire;
      logic [AW-1:0] ga;
      #2;
      rdy  = m_stall || !wb_valid;
      fire = mdu_valid && rdy;
      ga   = fire ? mdu_addr : wb_addr;
      chk({tag, ".ready"}, mdu_ready, rdy);
      chk({tag, ".stall"}, stall_wb, m_stall);
      chk({tag, ".we"}, rf_we, (fire || wb_valid) && ga != 0);
      chk({tag, ".waddr"}, rf_waddr, ga);
      chk({tag, ".wdata"}, rf_wdata, fire ? mdu_data : wb_data);
      chk({tag, ".hz1"}, hazard1, m_busy[rs1_addr] && !(fire && mdu_addr == rs1_addr));
      chk({tag, ".hz2"}, hazard2, m_busy[rs2_addr] && !(fire && mdu_addr == rs2_addr));
      chk({tag, ".busy"}, busy_mask, m_busy);
      chk({tag, ".perr"}, protocol_err, m_err);
      @(posedge clk);
      if (wb_valid && m_stall) m_err = 1;
      if (m_pend && !mdu_valid) m_err = 1;
      if (issue_valid && issue_addr != 0 && m_busy[issue_addr] && !(fire && mdu_addr == issue_addr)) m_err = 1;
      if (fire) m_busy[mdu_addr] = 0;
      if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1;
      m_pend = mdu_valid && !fire;
      if (mdu_valid && !rdy) begin
         m_wait++;
         m_stall = (m_wait >= MW);
         if (m_stall) m_wait = 0;
      end else begin
         m_wait = 0;
         m_stall = 0;
      end
      @(negedge clk);
   endtask

   task automatic reset_pulse();
      reset = 1;
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      model_reset();
   endtask

   initial begin
      bit fire;
      model_reset();
      @(negedge clk);
      #1;
      chk("rst.stall", stall_wb, 0);
      chk("rst.busy", busy_mask, 0);
      chk("rst.perr", protocol_err, 0);
      chk("rst.ready", mdu_ready, 0);
      chk("rst.we", rf_we, 0);
      @(negedge clk);
      reset = 0;
      // A alone
      wb_valid = 1; wb_addr = 5; wb_data = 32'h1234;
      #1;
      chk("a.we", rf_we, 1);
      chk("a.waddr", rf_waddr, 5);
      chk("a.wdata", rf_wdata, 32'h1234);
      chk("a.ready", mdu_ready, 0);
      step("a");
      // contention: B waits MW cycles, then a one-cycle stall grants it
      wb_addr = 3; wb_data = 32'h55;
      mdu_valid = 1; mdu_addr = 9; mdu_data = 32'hCAFE;
      for (int k = 0; k < MW; k++) begin
         #1;
         chk("cont.blocked", mdu_ready, 0);
         step("cont");
      end
      wb_valid = 0;
      #1;
      chk("cont.stall", stall_wb, 1);
      chk("cont.waddr", rf_waddr, 9);
      chk("cont.wdata", rf_wdata, 32'hCAFE);
      step("cont4");
      mdu_valid = 0;
      #1;
      chk("cont.unstall", stall_wb, 0);
      step("cont5");
      // scoreboard
      issue_valid = 1; issue_addr = 7; rs1_addr = 7; rs2_addr = 2;
      step("sb.issue");
      issue_valid = 0;
      #1;
      chk("sb.hz1", hazard1, 1);
      step("sb.wait");
      mdu_valid = 1; mdu_addr = 7; mdu_data = 32'h77;
      #1;
      chk("sb.fwd", hazard1, 0);
      step("sb.wr");
      mdu_valid = 0;
      #1;
      chk("sb.clr", busy_mask[7], 0);
      issue_valid = 1;
      step("sb.reissue");
      mdu_valid = 1;
      step("sb.both");
      mdu_valid = 0; issue_valid = 0;
      #1;
      chk("sb.setwins", busy_mask[7], 1);
      step("sb.hold");
      mdu_valid = 1;
      step("sb.drain");
      mdu_valid = 0;
      // register 0
      issue_valid = 1; issue_addr = 0;
      step("r0.issue");
      issue_valid = 0;
      #1;
      chk("r0.busy", busy_mask, 0);
      mdu_valid = 1; mdu_addr = 0; mdu_data = 32'hDEAD;
      #1;
      chk("r0.mready", mdu_ready, 1);
      chk("r0.mwe", rf_we, 0);
      step("r0.mdu");
      mdu_valid = 0; wb_valid = 1; wb_addr = 0;
      #1;
      chk("r0.awe", rf_we, 0);
      step("r0.a");
      // random legal traffic
      for (int i = 0; i < 400; i++) begin
         if (!m_pend) begin
            mdu_valid = ($urandom_range(0, 2) == 0);
            mdu_addr = AW'($urandom_range(0, 7));
            mdu_data = $urandom;
         end
         wb_valid = m_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
         wb_addr = AW'($urandom_range(0, NR - 1));
         wb_data = $urandom;
         rs1_addr = AW'($urandom_range(0, 7));
         rs2_addr = AW'($urandom_range(0, 7));
         issue_addr = AW'($urandom_range(0, 7));
         fire = mdu_valid && (m_stall || !wb_valid);
         issue_valid = ($urandom_range(0, 2) == 0) && !(m_busy[issue_addr] && !(fire && mdu_addr == issue_addr));
         step("rnd");
      end
      wb_valid = 0; issue_valid = 0;
      step("drain");
      mdu_valid = 0;
      step("drain2");
      // violation: A writes during the stall cycle
      reset_pulse();
      wb_valid = 1; wb_addr = 4; mdu_valid = 1; mdu_addr = 10; mdu_data = 32'hBEEF;
      for (int k = 0; k < MW; k++) step("v1.wait");
      #1;
      chk("v1.bwins", rf_waddr, 10);
      step("v1.stall");
      wb_valid = 0; mdu_valid = 0;
      #1;
      chk("v1.perr", protocol_err, 1);
      step("v1.hold");
      step("v1.hold2");
      reset_pulse();
      #1;
      chk("v1.perr_clr", protocol_err, 0);
      // violation: mdu_valid dropped while blocked
      wb_valid = 1; mdu_valid = 1; mdu_addr = 11;
      step("v2.blk");
      mdu_valid = 0;
      step("v2.drop");
      wb_valid = 0;
      #1;
      chk("v2.perr", protocol_err, 1);
      reset_pulse();
      // violation: issue to an already busy index
      issue_valid = 1; issue_addr = 4;
      step("v3.a");
      step("v3.b");
      issue_valid = 0;
      #1;
      chk("v3.perr", protocol_err, 1);
      reset_pulse();
      // asynchronous reset in the middle of WAIT
      issue_valid = 1; issue_addr = 7;
      step("ar.issue");
      issue_valid = 0;
      wb_valid = 1; wb_addr = 6; mdu_valid = 1; mdu_addr = 3;
      step("ar.w1");
      step("ar.w2");
      #1;
      chk("ar.busy_pre", busy_mask, 32'h80);
      reset = 1;
      #1;
      chk("ar.stall", stall_wb, 0);
      chk("ar.busy", busy_mask, 0);
      chk("ar.we", rf_we, 0);
      chk("ar.ready", mdu_ready, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      model_reset();
      for (int k = 0; k < MW; k++) step("ar.restart");
      #1;
      chk("ar.stall_after", stall_wb, 1);
      wb_valid = 0;
      step("ar.stall");
      mdu_valid = 0;
      step("ar.end");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources.
  - Source A: in-order pipeline writeback. Always has priority and has no ready signal.
  - Source B: long-latency multiply/divide unit (MDU). Uses a valid/ready handshake.
- Bounds B's starvation by issuing a one-cycle stall request to the pipeline.
- Keeps a pending-write scoreboard for MDU destinations and flags read-after-write hazards for the decode stage.
- Sits between the WB stage, the MDU and the register file write port.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register index width (2**ADDR_W registers; index 0 is hardwired zero).
- MAX_WAIT, 4, number of blocked cycles for B before stall_wb is forced (must be at least 1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- wb_valid  in  1  pipeline writeback request.
- wb_addr  in  ADDR_W  pipeline destination.
- wb_data  in  DATA_W  pipeline result.
- mdu_valid  in  1  MDU result valid; must hold until handshake.
- mdu_addr  in  ADDR_W  MDU destination.
- mdu_data  in  DATA_W  MDU result.
- mdu_ready  out  1  MDU result accepted this cycle.
- issue_valid  in  1  MDU operation issued this cycle.
- issue_addr  in  ADDR_W  destination of issued MDU operation.
- rs1_addr  in  ADDR_W  decode read address 1.
- rs2_addr  in  ADDR_W  decode read address 2.
- hazard1  out  1  rs1 waits on a pending MDU write.
- hazard2  out  1  rs2 waits on a pending MDU write.
- stall_wb  out  1  registered; pipeline must not present wb_valid this cycle.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- busy_mask  out  2**ADDR_W  scoreboard state; bit 0 always 0.
- protocol_err  out  1  sticky protocol violation flag.

Behaviour:
- Reset state (asynchronous): FSM in IDLE, wait counter 0, stall_wb 0, busy_mask 0, protocol_err 0.
- While reset is high: rf_we=0 and mdu_ready=0.
- mdu_ready = stall_wb | ~wb_valid. It does not depend on mdu_valid.
- mdu_fire = mdu_valid & mdu_ready.
- Grant is combinational, with zero latency to the write port:
  - If mdu_fire: write B's address and data.
  - Else if wb_valid: write A's address and data.
  - Otherwise rf_we=0.
- rf_we = granted valid & (granted addr != 0). Writes to register 0 complete their handshake but are dropped.
- When idle, rf_waddr/rf_wdata carry A's values.
- FSM:
  - IDLE: if mdu_valid & ~mdu_ready, go to WAIT with cnt=1, or go directly to STALL when MAX_WAIT=1.
  - WAIT: on each blocked cycle, cnt increments. When a blocked cycle occurs with cnt==MAX_WAIT-1, go to STALL. If mdu_fire or ~mdu_valid, return to IDLE with cnt=0.
  - STALL: stall_wb=1 for exactly this cycle and B is granted; always return to IDLE with cnt=0.
  - Worst-case latency from mdu_valid to handshake is MAX_WAIT+1 cycles.
- Scoreboard, updated on the clock edge:
  - Set busy[issue_addr] when issue_valid & issue_addr!=0.
  - Clear busy[mdu_addr] on mdu_fire.
  - Simultaneous set and clear of the same index: set wins.
- hazardN = busy[rsN] & ~(mdu_fire & mdu_addr==rsN). The register file forwards same-cycle write data, so a read of an address being written this cycle is not a hazard.
- protocol_err is set (sticky until reset) on any of:
  - wb_valid while stall_wb=1. B still wins and A's write is lost.
  - mdu_valid falling without mdu_fire.
  - issue_valid to an index already busy with no same-cycle clear.
- Pipeline writes to a busy register do not change the scoreboard.

Test Plan:
- A alone: wb_valid=1, wb_addr=5, wb_data=0x1234 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; mdu_ready=0.
- Contention with MAX_WAIT=4: wb_valid held high from cycle 0; mdu_valid=1, mdu_addr=9, mdu_data=0xCAFE from cycle 0 -> cycles 0-3 A is written and mdu_ready=0; cycle 4 stall_wb=1, rf_waddr=9, rf_wdata=0xCAFE, mdu_ready=1; cycle 5 stall_wb=0. Test drives wb_valid=0 in cycle 4.
- Scoreboard: issue_valid, issue_addr=7; rs1_addr=7 -> hazard1=1 from the next cycle. MDU writes addr 7 -> hazard1=0 in the handshake cycle and busy_mask[7]=0 after the edge. Same-cycle issue and write of addr 7 -> busy_mask[7] stays 1.
- Register 0: issue_addr=0 -> busy_mask unchanged. MDU write to addr 0 -> mdu_ready=1, rf_we=0. A write to addr 0 -> rf_we=0.
- Violations:
  - wb_valid=1 during a stall_wb cycle -> B is written and protocol_err=1, holding until reset.
  - Drop mdu_valid while blocked -> protocol_err=1.
- Reset during WAIT (cnt=2, busy_mask=0x80): assert reset asynchronously -> immediately stall_wb=0, busy_mask=0, rf_we=0, mdu_ready=0. After release, the FSM restarts its count from IDLE.
